// File: rtl/scope_pkg.sv
// ---------------------------------------------------------------------------
// scope_pkg
// Shared definitions for the scope acquisition core: capture/dump FSM state
// encoding, decimator limits, RAM lane width and a decimation mask helper.
// ---------------------------------------------------------------------------
package scope_pkg;

    // Largest decimator exponent; the sample counter is this many bits wide.
    localparam int MAX_DECIMATOR = 15;

    // Every RAM lane holds one byte per stored sample.
    localparam int LANE_W = 8;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_PRE   = 4'd1,
        ST_ARMED = 4'd2,
        ST_POST  = 4'd3,
        ST_DONE  = 4'd4,
        ST_DRD   = 4'd5,
        ST_DLAT  = 4'd6,
        ST_DSEND = 4'd7,
        ST_DWAIT = 4'd8
    } cde_state_t;

    // Wrap mask for the decimation counter: 2^d - 1.
    function automatic logic [MAX_DECIMATOR-1:0] dec_mask(input logic [3:0] d);
        logic [31:0] m;
        m = (32'd1 << d) - 32'd1;
        return m[MAX_DECIMATOR-1:0];
    endfunction

endpackage

// File: rtl/trig_sel_edge.sv
// ---------------------------------------------------------------------------
// trig_sel_edge
// Selects one trigger comparator level, remembers its previous-cycle value
// and reports a one-cycle event on the chosen edge polarity or on a force.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   trig_in      per-channel comparator levels (synchronous to clk)
//   trig_src     channel select; out-of-range selects a constant low level
//   trig_rise    1 = rising edge, 0 = falling edge
//   trig_force   immediate event request
//   trig_evt     combinational event, valid in the cycle the edge is seen
// ---------------------------------------------------------------------------
module trig_sel_edge #(
    parameter int NUM_CH = 3,
    parameter int CW     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] trig_in,
    input  logic [CW-1:0]     trig_src,
    input  logic              trig_rise,
    input  logic              trig_force,
    output logic              trig_evt
);

    logic sel_lvl;
    logic prev_lvl;
    logic edge_seen;

    always_comb begin
        sel_lvl = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (trig_src == CW'(k)) begin
                sel_lvl = trig_in[k];
            end
        end
    end

    // History follows the currently selected source so a change of source
    // while idle settles within one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_lvl <= 1'b0;
        end else begin
            prev_lvl <= sel_lvl;
        end
    end

    always_comb begin
        edge_seen = trig_rise ? (sel_lvl & ~prev_lvl) : (~sel_lvl & prev_lvl);
        trig_evt  = edge_seen | trig_force;
    end

endmodule

// File: rtl/capture_dump_engine.sv
// ---------------------------------------------------------------------------
// capture_dump_engine
// N-channel acquisition engine: decimates the ADC sample strobe into a
// circular capture RAM, arms after enough pre-trigger history has been
// stored, completes after trig_pos post-trigger samples, then dumps one
// channel's full record, oldest sample first, one byte per UART handshake.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   smpl_vld        ADC sample strobe
//   trig_in         per-channel trigger levels
//   trig_src        trigger channel select
//   trig_rise       trigger polarity (1 rising, 0 falling)
//   trig_force      forced trigger while armed
//   trig_pos        stored samples after the trigger
//   decimator       store one of every 2^decimator samples
//   arm             start capture (idle only)
//   clr_cap_done    release a completed capture
//   dump            start a dump (completed capture only)
//   dump_ch         lane to dump; out-of-range lanes read as zero
//   ram_rdata       RAM read data, lane k in bits [8k+7:8k], 1-cycle latency
//   resp_sent       UART finished the current byte
//   ram_we/en/addr  registered RAM controls shared by all lanes
//   capture_done    record complete, held until released
//   resp_data       byte for the UART
//   send_resp       one-cycle send request
//   dump_done       one-cycle pulse after the last byte is acknowledged
// ---------------------------------------------------------------------------
module capture_dump_engine
    import scope_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int DEPTH  = 512,
    parameter int AW     = $clog2(DEPTH),
    parameter int CW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     smpl_vld,
    input  logic [NUM_CH-1:0]        trig_in,
    input  logic [CW-1:0]            trig_src,
    input  logic                     trig_rise,
    input  logic                     trig_force,
    input  logic [AW-1:0]            trig_pos,
    input  logic [3:0]               decimator,
    input  logic                     arm,
    input  logic                     clr_cap_done,
    input  logic                     dump,
    input  logic [CW-1:0]            dump_ch,
    input  logic [NUM_CH*LANE_W-1:0] ram_rdata,
    input  logic                     resp_sent,
    output logic                     ram_we,
    output logic                     ram_en,
    output logic [AW-1:0]            ram_addr,
    output logic                     capture_done,
    output logic [LANE_W-1:0]        resp_data,
    output logic                     send_resp,
    output logic                     dump_done
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    cde_state_t               state;
    logic [MAX_DECIMATOR-1:0] dec_cnt;
    logic [MAX_DECIMATOR-1:0] dec_cnt_nxt;
    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            wr_ptr_nxt;
    logic [AW-1:0]            rd_ptr;
    logic [AW-1:0]            rd_ptr_nxt;
    logic [AW:0]              pre_cnt;
    logic [AW:0]              pre_cnt_nxt;
    logic [AW:0]              post_cnt;
    logic [AW:0]              post_cnt_nxt;
    logic [AW:0]              byte_cnt;
    logic [AW:0]              byte_cnt_nxt;
    logic [AW:0]              pre_target;
    logic                     capturing;
    logic                     store;
    logic                     trig_evt;
    logic [LANE_W-1:0]        lane_byte;

    trig_sel_edge #(
        .NUM_CH (NUM_CH),
        .CW     (CW)
    ) u_trig (
        .clk        (clk),
        .rst_n      (rst_n),
        .trig_in    (trig_in),
        .trig_src   (trig_src),
        .trig_rise  (trig_rise),
        .trig_force (trig_force),
        .trig_evt   (trig_evt)
    );

    // Pre-trigger history needed before the trigger may fire. trig_pos is
    // at most DEPTH-1, so the target is always at least one sample.
    always_comb begin
        pre_target   = DEPTH_W - {1'b0, trig_pos};
        capturing    = (state == ST_PRE) || (state == ST_ARMED) || (state == ST_POST);
        store        = capturing && smpl_vld && (dec_cnt == '0);
        dec_cnt_nxt  = (dec_cnt + 1'b1) & dec_mask(decimator);
        wr_ptr_nxt   = wr_ptr + 1'b1;
        rd_ptr_nxt   = rd_ptr + 1'b1;
        pre_cnt_nxt  = pre_cnt + 1'b1;
        post_cnt_nxt = post_cnt + 1'b1;
        byte_cnt_nxt = byte_cnt + 1'b1;
    end

    always_comb begin
        lane_byte = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (dump_ch == CW'(k)) begin
                lane_byte = ram_rdata[k*LANE_W +: LANE_W];
            end
        end
    end

    // Masking the increment keeps the counter in range even if it was left
    // above a smaller wrap point; arm restarts the decimation phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_cnt <= '0;
        end else if ((state == ST_IDLE) && arm) begin
            dec_cnt <= '0;
        end else if (smpl_vld) begin
            dec_cnt <= dec_cnt_nxt;
        end
    end

    // RAM controls are pulses rebuilt every cycle. For reads the address is
    // launched on entry to DRD, so the RAM answers during DLAT and the byte
    // is captured at the end of DLAT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            pre_cnt      <= '0;
            post_cnt     <= '0;
            byte_cnt     <= '0;
            ram_we       <= 1'b0;
            ram_en       <= 1'b0;
            ram_addr     <= '0;
            capture_done <= 1'b0;
            resp_data    <= '0;
            send_resp    <= 1'b0;
            dump_done    <= 1'b0;
        end else begin
            ram_we    <= 1'b0;
            ram_en    <= 1'b0;
            send_resp <= 1'b0;
            dump_done <= 1'b0;

            if (store) begin
                ram_we   <= 1'b1;
                ram_en   <= 1'b1;
                ram_addr <= wr_ptr;
                wr_ptr   <= wr_ptr_nxt;
            end

            case (state)
                ST_IDLE: begin
                    if (arm) begin
                        wr_ptr   <= '0;
                        pre_cnt  <= '0;
                        post_cnt <= '0;
                        state    <= ST_PRE;
                    end
                end
                ST_PRE: begin
                    if (store) begin
                        pre_cnt <= pre_cnt_nxt;
                        if (pre_cnt_nxt == pre_target) begin
                            state <= ST_ARMED;
                        end
                    end
                end
                ST_ARMED: begin
                    if (trig_evt) begin
                        if (trig_pos == '0) begin
                            capture_done <= 1'b1;
                            state        <= ST_DONE;
                        end else begin
                            state <= ST_POST;
                        end
                    end
                end
                ST_POST: begin
                    if (store) begin
                        post_cnt <= post_cnt_nxt;
                        if (post_cnt_nxt == {1'b0, trig_pos}) begin
                            capture_done <= 1'b1;
                            state        <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    // Release takes priority over a simultaneous dump request.
                    if (clr_cap_done) begin
                        capture_done <= 1'b0;
                        state        <= ST_IDLE;
                    end else if (dump) begin
                        rd_ptr   <= wr_ptr;
                        byte_cnt <= '0;
                        ram_en   <= 1'b1;
                        ram_addr <= wr_ptr;
                        state    <= ST_DRD;
                    end
                end
                ST_DRD: begin
                    state <= ST_DLAT;
                end
                ST_DLAT: begin
                    resp_data <= lane_byte;
                    send_resp <= 1'b1;
                    state     <= ST_DSEND;
                end
                ST_DSEND: begin
                    state <= ST_DWAIT;
                end
                ST_DWAIT: begin
                    if (resp_sent) begin
                        rd_ptr   <= rd_ptr_nxt;
                        byte_cnt <= byte_cnt_nxt;
                        if (byte_cnt_nxt == DEPTH_W) begin
                            dump_done <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            ram_en   <= 1'b1;
                            ram_addr <= rd_ptr_nxt;
                            state    <= ST_DRD;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_capture_dump_engine.sv
// ---------------------------------------------------------------------------
// tb_capture_dump_engine
// Self-checking bench for capture_dump_engine (NUM_CH=3, DEPTH=16). Random
// sample data and random activity on unselected trigger channels; expected
// records come from a list-based model of which samples get stored.
// ---------------------------------------------------------------------------
module tb_capture_dump_engine;

    localparam int NUM_CH = 3;
    localparam int DEPTH  = 16;
    localparam int AW     = 4;
    localparam int CW     = 2;
    localparam int DW     = NUM_CH * 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              smpl_vld;
    logic [NUM_CH-1:0] trig_in;
    logic [CW-1:0]     trig_src;
    logic              trig_rise;
    logic              trig_force;
    logic [AW-1:0]     trig_pos;
    logic [3:0]        decimator;
    logic              arm;
    logic              clr_cap_done;
    logic              dump;
    logic [CW-1:0]     dump_ch;
    logic [DW-1:0]     ram_rdata;
    logic              resp_sent;
    logic              ram_we;
    logic              ram_en;
    logic [AW-1:0]     ram_addr;
    logic              capture_done;
    logic [7:0]        resp_data;
    logic              send_resp;
    logic              dump_done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    capture_dump_engine #(
        .NUM_CH (NUM_CH),
        .DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .smpl_vld     (smpl_vld),
        .trig_in      (trig_in),
        .trig_src     (trig_src),
        .trig_rise    (trig_rise),
        .trig_force   (trig_force),
        .trig_pos     (trig_pos),
        .decimator    (decimator),
        .arm          (arm),
        .clr_cap_done (clr_cap_done),
        .dump         (dump),
        .dump_ch      (dump_ch),
        .ram_rdata    (ram_rdata),
        .resp_sent    (resp_sent),
        .ram_we       (ram_we),
        .ram_en       (ram_en),
        .ram_addr     (ram_addr),
        .capture_done (capture_done),
        .resp_data    (resp_data),
        .send_resp    (send_resp),
        .dump_done    (dump_done)
    );

    // Capture RAM: the ADC word is latched on its strobe and written when
    // the engine raises ram_we on the following cycle.
    logic [DW-1:0] adc_cur = '0;
    logic [DW-1:0] adc_q   = '0;
    logic [DW-1:0] mem [DEPTH];

    always @(posedge clk) begin
        if (smpl_vld) adc_q <= adc_cur;
        if (ram_en && ram_we) mem[ram_addr] <= adc_q;
        if (ram_en && !ram_we) ram_rdata <= mem[ram_addr];
    end

    // Observers and UART responder, away from the active edge.
    logic [AW-1:0] addr_log [$];
    logic [7:0]    byte_log [$];
    int            dump_done_cnt = 0;
    int            resp_delay    = 0;
    int            resp_wait     = 0;
    bit            resp_pend     = 1'b0;

    always @(negedge clk) begin
        if (ram_we) addr_log.push_back(ram_addr);
        if (send_resp) byte_log.push_back(resp_data);
        if (dump_done) dump_done_cnt++;
    end

    always @(negedge clk) begin
        resp_sent = 1'b0;
        if (!rst_n) begin
            resp_pend = 1'b0;
        end else if (send_resp) begin
            resp_pend = 1'b1;
            resp_wait = resp_delay;
        end else if (resp_pend) begin
            if (resp_wait <= 0) begin
                resp_sent = 1'b1;
                resp_pend = 1'b0;
            end else begin
                resp_wait--;
            end
        end
    end

    // Reference model state.
    logic [DW-1:0] smp_q   [$];
    logic [DW-1:0] exp_rec [$];
    int            exp_stores;
    int            cur_src;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_sample();
        logic [DW-1:0] d;
        d = DW'($urandom);
        @(posedge clk);
        #1;
        smpl_vld = 1'b1;
        adc_cur  = d;
        for (int k = 0; k < NUM_CH; k++) begin
            if (k != cur_src) trig_in[k] = 1'($urandom);
        end
        smp_q.push_back(d);
        tick(1);
        smpl_vld = 1'b0;
        tick($urandom_range(0, 2));
    endtask

    task automatic start_capture(input int dec, input int tpos, input int src, input bit rise);
        decimator = 4'(dec);
        trig_pos  = AW'(tpos);
        trig_src  = CW'(src);
        trig_rise = rise;
        cur_src   = src;
        trig_in[src] = ~rise;
        tick(3);
        addr_log.delete();
        smp_q.delete();
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
    endtask

    task automatic fire_trigger(input bit use_force);
        if (use_force) begin
            trig_force = 1'b1;
            tick(1);
            trig_force = 1'b0;
        end else begin
            trig_in[cur_src] = trig_rise;
            tick(1);
        end
    endtask

    // Which sample indices are stored: every 2^dec-th strobe since arm, all
    // strobes before the trigger, then exactly tpos more. The record is the
    // last DEPTH of those, oldest first.
    task automatic build_model(input int dec, input int tpos, input int n_before);
        int st [$];
        int step;
        int n_pre;
        int k;
        step = 1 << dec;
        for (int i = 0; i < n_before; i++) begin
            if (i % step == 0) st.push_back(i);
        end
        n_pre = st.size();
        k = n_before;
        while (st.size() < n_pre + tpos) begin
            if (k % step == 0) st.push_back(k);
            k++;
        end
        exp_stores = st.size();
        exp_rec.delete();
        for (int j = st.size() - DEPTH; j < st.size(); j++) exp_rec.push_back(smp_q[st[j]]);
    endtask

    task automatic run_dump(input int ch, input int delay, input bit clr_mid, output bit timed_out);
        int cyc;
        int dd0;
        cyc = 0;
        dd0 = dump_done_cnt;
        byte_log.delete();
        resp_delay = delay;
        dump_ch = CW'(ch);
        dump = 1'b1;
        tick(1);
        dump = 1'b0;
        while (dump_done_cnt == dd0 && cyc < 4000) begin
            clr_cap_done = clr_mid && (cyc == 40);
            tick(1);
            cyc++;
        end
        clr_cap_done = 1'b0;
        timed_out = (dump_done_cnt == dd0);
        tick(3);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if ({ram_we, ram_en, ram_addr, capture_done, resp_data, send_resp, dump_done} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got %b, want all zero",
                     {ram_we, ram_en, ram_addr, capture_done, resp_data, send_resp, dump_done});
        end
        tick(2);
        rst_n = 1'b1;
        tick(2);
        checks++;
        if ({ram_we, ram_en, ram_addr, capture_done, resp_data, send_resp, dump_done} !== '0) begin
            failures++;
            $display("[TB] FAIL post_reset_outputs: got %b, want all zero",
                     {ram_we, ram_en, ram_addr, capture_done, resp_data, send_resp, dump_done});
        end
        byte_log.delete();
        dump = 1'b1;
        clr_cap_done = 1'b1;
        tick(1);
        dump = 1'b0;
        clr_cap_done = 1'b0;
        tick(10);
        checks++;
        if (byte_log.size() != 0 || capture_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL idle_dump_ignored: bytes=%0d capture_done=%b, want 0 and 0",
                     byte_log.size(), capture_done);
        end
    endtask

    task automatic test_basic();
        bit to;
        start_capture(0, 4, 1, 1'b1);
        for (int i = 0; i < 19; i++) send_sample();
        fire_trigger(1'b0);
        for (int i = 0; i < 8; i++) send_sample();
        tick(4);
        build_model(0, 4, 19);
        checks++;
        if (capture_done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL basic_capture_done: got %b want 1", capture_done);
        end
        checks++;
        if (addr_log.size() != exp_stores) begin
            failures++;
            $display("[TB] FAIL basic_write_count: got %0d want %0d", addr_log.size(), exp_stores);
        end
        for (int i = 0; i < addr_log.size(); i++) begin
            checks++;
            if (addr_log[i] !== AW'(i)) begin
                failures++;
                $display("[TB] FAIL basic_addr[%0d]: got %0d want %0d", i, addr_log[i], i % DEPTH);
            end
        end
        for (int ch = 0; ch < NUM_CH; ch += 2) begin
            run_dump(ch, 2, 1'b0, to);
            checks++;
            if (to || byte_log.size() != DEPTH) begin
                failures++;
                $display("[TB] FAIL basic_dump_len ch%0d: got %0d bytes timeout=%0d want %0d",
                         ch, byte_log.size(), to, DEPTH);
            end
            for (int j = 0; j < DEPTH && j < byte_log.size(); j++) begin
                logic [DW-1:0] w;
                w = exp_rec[j];
                checks++;
                if (byte_log[j] !== w[ch*8 +: 8]) begin
                    failures++;
                    $display("[TB] FAIL basic_dump_byte ch%0d[%0d]: got %h want %h",
                             ch, j, byte_log[j], w[ch*8 +: 8]);
                end
            end
        end
        clr_cap_done = 1'b1;
        tick(1);
        clr_cap_done = 1'b0;
        tick(1);
        checks++;
        if (capture_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_clear: got %b want 0", capture_done);
        end
    endtask

    task automatic test_decimation();
        bit to;
        start_capture(2, 3, 0, 1'b1);
        for (int i = 0; i < 53; i++) send_sample();
        fire_trigger(1'b0);
        for (int i = 0; i < 16; i++) send_sample();
        tick(4);
        build_model(2, 3, 53);
        checks++;
        if (capture_done !== 1'b1 || addr_log.size() != exp_stores) begin
            failures++;
            $display("[TB] FAIL dec_writes: done=%b writes=%0d want 1 and %0d",
                     capture_done, addr_log.size(), exp_stores);
        end
        for (int i = 0; i < addr_log.size(); i++) begin
            checks++;
            if (addr_log[i] !== AW'(i)) begin
                failures++;
                $display("[TB] FAIL dec_addr[%0d]: got %0d want %0d", i, addr_log[i], i % DEPTH);
            end
        end
        run_dump(0, 0, 1'b0, to);
        checks++;
        if (to || byte_log.size() != DEPTH) begin
            failures++;
            $display("[TB] FAIL dec_dump_len: got %0d timeout=%0d want %0d", byte_log.size(), to, DEPTH);
        end
        for (int j = 0; j < DEPTH && j < byte_log.size(); j++) begin
            logic [DW-1:0] w;
            w = exp_rec[j];
            checks++;
            if (byte_log[j] !== w[7:0]) begin
                failures++;
                $display("[TB] FAIL dec_dump_byte[%0d]: got %h want %h", j, byte_log[j], w[7:0]);
            end
        end
        clr_cap_done = 1'b1;
        tick(1);
        clr_cap_done = 1'b0;
        tick(1);
    endtask

    task automatic test_pre_edge_falling();
        bit to;
        start_capture(0, 0, 2, 1'b0);
        for (int i = 0; i < 20; i++) begin
            send_sample();
            if (i == 3) begin
                trig_in[2] = 1'b0;
                trig_force = 1'b1;
                tick(1);
                trig_force = 1'b0;
                trig_in[2] = 1'b1;
                tick(1);
            end
        end
        fire_trigger(1'b0);
        for (int i = 0; i < 6; i++) send_sample();
        tick(4);
        build_model(0, 0, 20);
        checks++;
        if (capture_done !== 1'b1 || addr_log.size() != exp_stores) begin
            failures++;
            $display("[TB] FAIL pre_edge_writes: done=%b writes=%0d want 1 and %0d",
                     capture_done, addr_log.size(), exp_stores);
        end
        run_dump(2, 1, 1'b0, to);
        checks++;
        if (to || byte_log.size() != DEPTH) begin
            failures++;
            $display("[TB] FAIL pre_edge_dump_len: got %0d timeout=%0d want %0d", byte_log.size(), to, DEPTH);
        end
        for (int j = 0; j < DEPTH && j < byte_log.size(); j++) begin
            logic [DW-1:0] w;
            w = exp_rec[j];
            checks++;
            if (byte_log[j] !== w[23:16]) begin
                failures++;
                $display("[TB] FAIL pre_edge_dump_byte[%0d]: got %h want %h", j, byte_log[j], w[23:16]);
            end
        end
        clr_cap_done = 1'b1;
        tick(1);
        clr_cap_done = 1'b0;
        tick(1);
    endtask

    task automatic test_force_bad_lane();
        bit to;
        int bad;
        start_capture(0, 5, 0, 1'b1);
        for (int i = 0; i < 11; i++) send_sample();
        fire_trigger(1'b1);
        for (int i = 0; i < 10; i++) send_sample();
        tick(4);
        build_model(0, 5, 11);
        checks++;
        if (capture_done !== 1'b1 || addr_log.size() != exp_stores) begin
            failures++;
            $display("[TB] FAIL force_writes: done=%b writes=%0d want 1 and %0d",
                     capture_done, addr_log.size(), exp_stores);
        end
        run_dump(3, 0, 1'b0, to);
        bad = 0;
        foreach (byte_log[j]) if (byte_log[j] !== 8'h00) bad++;
        checks++;
        if (to || byte_log.size() != DEPTH || bad != 0) begin
            failures++;
            $display("[TB] FAIL bad_lane_dump: bytes=%0d nonzero=%0d timeout=%0d want %0d, 0, 0",
                     byte_log.size(), bad, to, DEPTH);
        end
        clr_cap_done = 1'b1;
        tick(1);
        clr_cap_done = 1'b0;
        tick(1);
    endtask

    task automatic test_slow_dump();
        bit to;
        start_capture(1, 6, 1, 1'b1);
        for (int i = 0; i < 25; i++) send_sample();
        fire_trigger(1'b0);
        for (int i = 0; i < 14; i++) send_sample();
        tick(4);
        build_model(1, 6, 25);
        checks++;
        if (addr_log.size() != exp_stores) begin
            failures++;
            $display("[TB] FAIL slow_writes: got %0d want %0d", addr_log.size(), exp_stores);
        end
        run_dump(1, 50, 1'b1, to);
        checks++;
        if (to || byte_log.size() != DEPTH) begin
            failures++;
            $display("[TB] FAIL slow_send_count: got %0d timeout=%0d want %0d", byte_log.size(), to, DEPTH);
        end
        for (int j = 0; j < DEPTH && j < byte_log.size(); j++) begin
            logic [DW-1:0] w;
            w = exp_rec[j];
            checks++;
            if (byte_log[j] !== w[15:8]) begin
                failures++;
                $display("[TB] FAIL slow_dump_byte[%0d]: got %h want %h", j, byte_log[j], w[15:8]);
            end
        end
        checks++;
        if (capture_done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL slow_clr_ignored: capture_done=%b want 1", capture_done);
        end
        clr_cap_done = 1'b1;
        tick(1);
        clr_cap_done = 1'b0;
        tick(1);
        checks++;
        if (capture_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL slow_clear: got %b want 0", capture_done);
        end
    endtask

    task automatic test_reset_abort();
        int cyc;
        int dd0;
        start_capture(0, 4, 0, 1'b1);
        for (int i = 0; i < 5; i++) send_sample();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ram_we, ram_en, ram_addr, capture_done, resp_data, send_resp, dump_done} !== '0) begin
            failures++;
            $display("[TB] FAIL abort_pre_outputs: got %b want all zero",
                     {ram_we, ram_en, ram_addr, capture_done, resp_data, send_resp, dump_done});
        end
        tick(2);
        rst_n = 1'b1;
        tick(2);

        start_capture(0, 2, 0, 1'b1);
        for (int i = 0; i < 14; i++) send_sample();
        fire_trigger(1'b0);
        for (int i = 0; i < 4; i++) send_sample();
        tick(4);
        byte_log.delete();
        resp_delay = 50;
        dump_ch = 2'd0;
        dump = 1'b1;
        tick(1);
        dump = 1'b0;
        cyc = 0;
        while (byte_log.size() == 0 && cyc < 100) begin
            tick(1);
            cyc++;
        end
        checks++;
        if (byte_log.size() == 0) begin
            failures++;
            $display("[TB] FAIL abort_first_byte: no send_resp within 100 cycles, want one");
        end
        tick(10);
        dd0 = dump_done_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ram_we, ram_en, ram_addr, capture_done, resp_data, send_resp, dump_done} !== '0) begin
            failures++;
            $display("[TB] FAIL abort_dwait_outputs: got %b want all zero",
                     {ram_we, ram_en, ram_addr, capture_done, resp_data, send_resp, dump_done});
        end
        tick(3);
        rst_n = 1'b1;
        tick(100);
        checks++;
        if (dump_done_cnt != dd0 || byte_log.size() != 1) begin
            failures++;
            $display("[TB] FAIL abort_no_dump_done: dump_done pulses=%0d bytes=%0d want 0 and 1",
                     dump_done_cnt - dd0, byte_log.size());
        end
    endtask

    initial begin
        smpl_vld     = 1'b0;
        trig_in      = '0;
        trig_src     = '0;
        trig_rise    = 1'b1;
        trig_force   = 1'b0;
        trig_pos     = '0;
        decimator    = '0;
        arm          = 1'b0;
        clr_cap_done = 1'b0;
        dump         = 1'b0;
        dump_ch      = '0;
        cur_src      = 0;
        test_reset();
        test_basic();
        test_decimation();
        test_pre_edge_falling();
        test_force_bad_lane();
        test_slow_dump();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
